// File: rtl/ows_frame_sender.sv
// Master-side 1-wire frame sequencer: reset/presence request followed by a
// byte-wise frame (ROM, UID, FUN, ADDR lo/hi, DATA) over a valid/ready handshake.
module ows_frame_sender #(
  parameter int unsigned           data_width   = 8,
  parameter logic [data_width-1:0] skip_rom_cmd = 8'hCC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [data_width-1:0] rom_cmd,
  input  logic [63:0]           uid,
  input  logic [data_width-1:0] fun_cmd,
  input  logic [15:0]           address,
  input  logic [data_width-1:0] wr_data,
  output logic                  ow_rst_req,
  input  logic                  ow_rst_done,
  input  logic                  ow_presence,
  output logic [data_width-1:0] tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  no_presence,
  output logic [3:0]            byte_idx
);

  typedef enum logic [2:0] {
    IDLE, RST_REQ, RST_WAIT, LOAD, SEND, DONE, ERR
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] rom_q, rom_d, fun_q, fun_d, wdat_q, wdat_d;
  logic [63:0]           uid_q, uid_d;
  logic [15:0]           addr_q, addr_d;
  logic [data_width-1:0] tx_byte_q, tx_byte_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  ow_rst_req_q, ow_rst_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  no_presence_q, no_presence_d;
  logic [3:0]            byte_idx_q, byte_idx_d;

  logic [data_width-1:0] field_sel;
  logic [3:0]            next_idx;
  logic [2:0]            uid_sel;

  // Field selected by the current frame index; SKIP ROM jumps from ROM straight to FUN.
  always_comb begin
    uid_sel = 3'(byte_idx_q - 4'd1);
    case (byte_idx_q)
      4'd0:                 field_sel = rom_q;
      4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8: field_sel = data_width'(uid_q[{uid_sel, 3'b000} +: 8]);
      4'd9:                 field_sel = fun_q;
      4'd10:                field_sel = data_width'(addr_q[7:0]);
      4'd11:                field_sel = data_width'(addr_q[15:8]);
      default:              field_sel = wdat_q;
    endcase
    next_idx = (byte_idx_q == 4'd0 && rom_q == skip_rom_cmd) ? 4'd9 : byte_idx_q + 4'd1;
  end

  always_comb begin
    state_d       = state_q;
    rom_d         = rom_q;
    uid_d         = uid_q;
    fun_d         = fun_q;
    addr_d        = addr_q;
    wdat_d        = wdat_q;
    tx_byte_d     = tx_byte_q;
    tx_valid_d    = tx_valid_q;
    byte_idx_d    = byte_idx_q;
    ow_rst_req_d  = 1'b0;
    done_d        = 1'b0;
    no_presence_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          rom_d   = rom_cmd;
          uid_d   = uid;
          fun_d   = fun_cmd;
          addr_d  = address;
          wdat_d  = wr_data;
          state_d = RST_REQ;
        end
      end
      RST_REQ: begin
        ow_rst_req_d = 1'b1;
        state_d      = RST_WAIT;
      end
      RST_WAIT: begin
        if (ow_rst_done) begin
          if (ow_presence) begin
            byte_idx_d = 4'd0;
            state_d    = LOAD;
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        tx_byte_d  = field_sel;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_idx_q == 4'd12) begin
            state_d = DONE;
          end else begin
            byte_idx_d = next_idx;
            state_d    = LOAD;
          end
        end
      end
      DONE: begin
        done_d     = 1'b1;
        byte_idx_d = 4'd0;
        state_d    = IDLE;
      end
      ERR: begin
        no_presence_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every state transition, including the completion pulses.
    if (abort && state_q != IDLE) begin
      state_d       = IDLE;
      tx_valid_d    = 1'b0;
      ow_rst_req_d  = 1'b0;
      byte_idx_d    = 4'd0;
      done_d        = 1'b0;
      no_presence_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rom_q         <= '0;
      uid_q         <= '0;
      fun_q         <= '0;
      addr_q        <= '0;
      wdat_q        <= '0;
      tx_byte_q     <= '0;
      tx_valid_q    <= 1'b0;
      ow_rst_req_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      no_presence_q <= 1'b0;
      byte_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      rom_q         <= rom_d;
      uid_q         <= uid_d;
      fun_q         <= fun_d;
      addr_q        <= addr_d;
      wdat_q        <= wdat_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
      ow_rst_req_q  <= ow_rst_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      no_presence_q <= no_presence_d;
      byte_idx_q    <= byte_idx_d;
    end
  end

  assign ow_rst_req  = ow_rst_req_q;
  assign tx_byte     = tx_byte_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign no_presence = no_presence_q;
  assign byte_idx    = byte_idx_q;

endmodule

// File: doc/ows_frame_sender.md
Name: ows_frame_sender

Overview:
- Master-side 1-wire frame sequencer; it is the transmit counterpart of the slave's byte parser.
- On `start`, it requests a bus reset/presence cycle from the line driver.
- It then streams a frame byte by byte to the bit-level transmitter over a valid/ready handshake, in this order: ROM command, 64-bit UID (omitted for SKIP ROM), function command, 16-bit address, one write-data byte.
- It sits between the host register interface and the 1-wire bit engine.

Parameters:
- `data_width`, 8, byte width of every frame field.
- `skip_rom_cmd`, 8'hCC, ROM command value that suppresses the UID bytes.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to send a frame; sampled only in IDLE.
- `abort`  in  1  terminates any frame in progress.
- `rom_cmd`  in  data_width  ROM command byte.
- `uid`  in  64  device UID, byte 0 = bits [7:0].
- `fun_cmd`  in  data_width  function command byte.
- `address`  in  16  target address.
- `wr_data`  in  data_width  data byte.
- `ow_rst_req`  out  1  pulse requesting a reset/presence cycle from the line driver.
- `ow_rst_done`  in  1  pulse: reset/presence cycle finished.
- `ow_presence`  in  1  presence detected; valid while `ow_rst_done`=1.
- `tx_byte`  out  data_width  byte to the bit engine.
- `tx_valid`  out  1  `tx_byte` valid.
- `tx_ready`  in  1  bit engine accepts the byte.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: frame completed.
- `no_presence`  out  1  one-cycle pulse: reset cycle saw no presence.
- `byte_idx`  out  4  index of the current byte within the frame.

Behaviour:
- **Reset (`rst_n`=0, asynchronous):** all outputs 0, state IDLE, field registers 0.
- **Input capture:** `start` in IDLE latches `rom_cmd`, `uid`, `fun_cmd`, `address` and `wr_data` into internal registers. Input changes after that cycle have no effect on the frame.
- **States:** IDLE, RST_REQ, RST_WAIT, LOAD, SEND, DONE, ERR.
- **IDLE:** on `start`=1 → RST_REQ. `busy` rises the next cycle.
- **RST_REQ:** `ow_rst_req`=1 for exactly one cycle → RST_WAIT.
- **RST_WAIT:** waits indefinitely for `ow_rst_done`.
  - `ow_rst_done`=1 and `ow_presence`=1 → LOAD with `byte_idx`=0.
  - `ow_rst_done`=1 and `ow_presence`=0 → ERR.
- **Frame sequence:** `byte_idx` 0 = ROM; 1..8 = UID bytes 0..7; 9 = FUN; 10 = ADDR[7:0]; 11 = ADDR[15:8]; 12 = DATA.
  - If the latched ROM command equals `skip_rom_cmd`, after index 0 the next index is 9.
- **LOAD:** drives `tx_byte` from the latched field for `byte_idx`, sets `tx_valid`=1 → SEND.
- **SEND:**
  - A byte transfers on the cycle where `tx_valid`=1 and `tx_ready`=1.
  - While `tx_ready`=0, `tx_byte` and `tx_valid` hold stable.
  - On transfer at index 12 → DONE. Otherwise advance the index and go to LOAD.
  - `tx_valid` drops for exactly one cycle (LOAD) between bytes.
- **Frame length:** 13 bytes for a normal frame, 5 bytes for SKIP ROM.
- **DONE:** `done`=1 for one cycle → IDLE.
- **ERR:** `no_presence`=1 for one cycle → IDLE. No bytes are sent.
- **abort** (any non-IDLE state, highest priority after reset):
  - Next cycle: state IDLE, `tx_valid`=0, `ow_rst_req`=0, `byte_idx`=0.
  - No `done` and no `no_presence` pulse.
  - If `abort` and `tx_ready` are high in the same cycle as a transfer, the byte counts as sent, but the frame is still abandoned.
- **`start` while busy:** ignored; no queuing.
- **`start` and `abort` together in IDLE:** `abort` wins; the frame does not start.
- **`ow_rst_done` outside RST_WAIT:** ignored.
- **Asynchronous reset mid-frame:** `tx_valid` falls immediately, with no handshake completion.

Test Plan:
- **Normal frame with zero-wait handshake:**
  - Stimulus: rom_cmd=8'h55, uid=64'h0123456789ABCDEF, fun_cmd=8'h0F, address=16'h1234, wr_data=8'hA5; `ow_presence`=1; `tx_ready` tied 1.
  - Required: tx_byte sequence 55, EF, CD, AB, 89, 67, 45, 23, 01, 0F, 34, 12, A5.
  - Required: `done` 2 cycles after the last transfer; `busy` low afterwards.
- **SKIP ROM frame:**
  - Stimulus: rom_cmd=8'hCC, fun_cmd=8'hF0, address=16'h0010, wr_data=8'h3C.
  - Required: exactly 5 bytes CC, F0, 10, 00, 3C; `byte_idx` jumps 0→9.
- **Missing presence:**
  - Stimulus: `ow_rst_done` pulse with `ow_presence`=0.
  - Required: `no_presence` pulses once; `tx_valid` never asserts; back to IDLE.
- **Backpressure:**
  - Stimulus: `tx_ready` low for 7 cycles on byte 3.
  - Required: `tx_byte`=8'hCD and `tx_valid`=1 held stable throughout; sequence otherwise unchanged.
- **Abort:**
  - Stimulus: assert `abort` during SEND at `byte_idx`=5.
  - Required: `tx_valid`=0 the next cycle, `busy`=0, no `done`.
  - Required: a following `start` runs a complete fresh frame from the ROM byte.
- **Stray inputs:**
  - Stimulus: a second `start` during SEND; `rst_n` pulsed low mid-frame.
  - Required: the second `start` has no effect; the reset clears all outputs to 0 asynchronously.
